cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/cpu_sequencer_if.sv | 36 +++
 rtl/cpu_int_latch.sv | 31 +++
 rtl/cpu_sequencer.sv | 136 +++++++++++++
 tb/tb_cpu_sequencer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the CPU cycle sequencer: phase and interrupt-kind encodings.
package cpu_pkg;

  typedef enum logic [2:0] {
    PH_RESET,
    PH_OPFETCH,
    PH_ADDR,
    PH_EXEC,
    PH_INT,
    PH_WAIT,
    PH_STOP
  } seq_phase_type;

  typedef enum logic [1:0] {
    INT_RESET,
    INT_NMI,
    INT_IRQ
  } int_kind_type;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bundle of the sequencer's decode/interrupt inputs and its phase/step outputs.
interface cpu_sequencer_if #(
  parameter int STEP_W = 4
) ();

  logic                    cpu_en;
  logic [7:0]              mem_rdata;
  logic                    addr_none;
  logic                    addr_last;
  logic                    exec_last;
  logic                    int_last;
  logic                    wai_op;
  logic                    stp_op;
  logic                    nmi_n;
  logic                    irq_n;
  logic                    p_i;
  cpu_pkg::seq_phase_type  phase;
  logic [STEP_W-1:0]       step;
  logic [7:0]              opcode;
  logic                    irq_req;
  cpu_pkg::int_kind_type   int_kind;
  logic                    seq_err;

  modport master (
    output cpu_en, mem_rdata, addr_none, addr_last, exec_last, int_last,
           wai_op, stp_op, nmi_n, irq_n, p_i,
    input  phase, step, opcode, irq_req, int_kind, seq_err
  );

  modport slave (
    input  cpu_en, mem_rdata, addr_none, addr_last, exec_last, int_last,
           wai_op, stp_op, nmi_n, irq_n, p_i,
    output phase, step, opcode, irq_req, int_kind, seq_err
  );

endinterface

// File: rtl/cpu_int_latch.sv
// NMI falling-edge detector and pending flag; samples every clk, independent of cpu_en.
module cpu_int_latch (
  input  logic clk,
  input  logic reset_n,
  input  logic nmi_n,
  input  logic clr,
  output logic nmi_pend
);

  logic nmi_s_q, nmi_s_d;
  logic pend_q, pend_d;

  // A fresh edge wins over a same-cycle clear so no NMI is lost.
  always_comb begin
    nmi_s_d = nmi_n;
    pend_d  = (nmi_s_q & ~nmi_n) | (pend_q & ~clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nmi_s_q <= 1'b1;
      pend_q  <= 1'b0;
    end else begin
      nmi_s_q <= nmi_s_d;
      pend_q  <= pend_d;
    end
  end

  assign nmi_pend = pend_q;

endmodule

// File: rtl/cpu_sequencer.sv
// CPU cycle sequencer: walks RESET/OPFETCH/ADDR/EXEC/INT/WAIT/STOP phases with a
// saturating step counter and NMI/IRQ arbitration at opcode fetch.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_en,
  input  logic [7:0]        mem_rdata,
  input  logic              addr_none,
  input  logic              addr_last,
  input  logic              exec_last,
  input  logic              int_last,
  input  logic              wai_op,
  input  logic              stp_op,
  input  logic              nmi_n,
  input  logic              irq_n,
  input  logic              p_i,
  output seq_phase_type     phase,
  output logic [STEP_W-1:0] step,
  output logic [7:0]        opcode,
  output logic              irq_req,
  output int_kind_type      int_kind,
  output logic              seq_err
);

  localparam logic [STEP_W-1:0] STEP_MAX = '1;

  seq_phase_type     phase_q, phase_d;
  logic [STEP_W-1:0] step_q, step_d, step_sat;
  logic [7:0]        opcode_q, opcode_d;
  int_kind_type      int_kind_q, int_kind_d;
  logic              seq_err_q, seq_err_d;
  logic              nmi_pend, nmi_clr, int_pend, step_ovf;

  cpu_int_latch u_int_latch (
    .clk      (clk),
    .reset_n  (reset_n),
    .nmi_n    (nmi_n),
    .clr      (nmi_clr),
    .nmi_pend (nmi_pend)
  );

  assign int_pend = nmi_pend | (~irq_n & ~p_i);
  assign step_ovf = (step_q == STEP_MAX);
  assign step_sat = step_ovf ? step_q : step_q + STEP_W'(1);

  always_comb begin
    phase_d    = phase_q;
    step_d     = step_q;
    opcode_d   = opcode_q;
    int_kind_d = int_kind_q;
    seq_err_d  = seq_err_q;
    nmi_clr    = 1'b0;
    if (cpu_en) begin
      unique case (phase_q)
        PH_RESET: begin
          phase_d    = PH_INT;
          step_d     = '0;
          int_kind_d = INT_RESET;
        end
        PH_OPFETCH: begin
          step_d = '0;
          if (int_pend) begin
            phase_d    = PH_INT;
            int_kind_d = nmi_pend ? INT_NMI : INT_IRQ;
            nmi_clr    = nmi_pend;
          end else begin
            opcode_d = mem_rdata;
            phase_d  = addr_none ? PH_EXEC : PH_ADDR;
          end
        end
        PH_ADDR: begin
          if (addr_last) begin
            phase_d = PH_EXEC;
            step_d  = '0;
          end else begin
            step_d    = step_sat;
            seq_err_d = seq_err_q | step_ovf;
          end
        end
        PH_EXEC: begin
          if (exec_last) begin
            phase_d = stp_op ? PH_STOP : (wai_op ? PH_WAIT : PH_OPFETCH);
            step_d  = '0;
          end else begin
            step_d    = step_sat;
            seq_err_d = seq_err_q | step_ovf;
          end
        end
        PH_INT: begin
          if (int_last) begin
            phase_d = PH_OPFETCH;
            step_d  = '0;
          end else begin
            step_d    = step_sat;
            seq_err_d = seq_err_q | step_ovf;
          end
        end
        // IRQ wakes from WAIT even when masked; the fetch then decides whether to take it.
        PH_WAIT: if (nmi_pend | ~irq_n) phase_d = PH_OPFETCH;
        PH_STOP: phase_d = PH_STOP;
        default: begin
          phase_d = PH_RESET;
          step_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q    <= PH_RESET;
      step_q     <= '0;
      opcode_q   <= 8'h00;
      int_kind_q <= INT_RESET;
      seq_err_q  <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      step_q     <= step_d;
      opcode_q   <= opcode_d;
      int_kind_q <= int_kind_d;
      seq_err_q  <= seq_err_d;
    end
  end

  assign phase    = phase_q;
  assign step     = step_q;
  assign opcode   = (phase_q == PH_OPFETCH) ? mem_rdata : opcode_q;
  assign irq_req  = int_pend | ((phase_q == PH_WAIT) & ~irq_n);
  assign int_kind = int_kind_q;
  assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed scenarios plus randomized cycles, checked against a cycle-level model.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int STEP_W = 4;
  localparam int SMAX   = (1 << STEP_W) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cpu_sequencer_if #(.STEP_W(STEP_W)) bus ();

  cpu_sequencer #(.STEP_W(STEP_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_en    (bus.cpu_en),
    .mem_rdata (bus.mem_rdata),
    .addr_none (bus.addr_none),
    .addr_last (bus.addr_last),
    .exec_last (bus.exec_last),
    .int_last  (bus.int_last),
    .wai_op    (bus.wai_op),
    .stp_op    (bus.stp_op),
    .nmi_n     (bus.nmi_n),
    .irq_n     (bus.irq_n),
    .p_i       (bus.p_i),
    .phase     (bus.phase),
    .step      (bus.step),
    .opcode    (bus.opcode),
    .irq_req   (bus.irq_req),
    .int_kind  (bus.int_kind),
    .seq_err   (bus.seq_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  seq_phase_type m_phase;
  int            m_step;
  logic [7:0]    m_op;
  int_kind_type  m_kind;
  bit            m_pend, m_err, m_nprev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_RESET; m_step = 0; m_op = 8'h00; m_kind = INT_RESET;
    m_pend = 1'b0; m_err = 1'b0; m_nprev = 1'b1;
  endtask

  task automatic bump();
    if (m_step == SMAX) m_err = 1'b1;
    else m_step++;
  endtask

  // One enabled/disabled clock of the architectural behaviour.
  task automatic model_step();
    bit nedge, pend_old, clr, ipend;
    nedge    = m_nprev && !bus.nmi_n;
    pend_old = m_pend;
    clr      = 1'b0;
    ipend    = pend_old || (!bus.irq_n && !bus.p_i);
    if (bus.cpu_en) begin
      case (m_phase)
        PH_RESET: begin m_phase = PH_INT; m_step = 0; m_kind = INT_RESET; end
        PH_OPFETCH:
          if (ipend) begin
            m_phase = PH_INT; m_step = 0;
            m_kind = pend_old ? INT_NMI : INT_IRQ;
            clr = pend_old;
          end else begin
            m_op = bus.mem_rdata; m_step = 0;
            m_phase = bus.addr_none ? PH_EXEC : PH_ADDR;
          end
        PH_ADDR: if (bus.addr_last) begin m_phase = PH_EXEC; m_step = 0; end else bump();
        PH_EXEC:
          if (bus.exec_last) begin
            m_step = 0;
            if (bus.stp_op)      m_phase = PH_STOP;
            else if (bus.wai_op) m_phase = PH_WAIT;
            else                 m_phase = PH_OPFETCH;
          end else bump();
        PH_INT: if (bus.int_last) begin m_phase = PH_OPFETCH; m_step = 0; end else bump();
        PH_WAIT: if (pend_old || !bus.irq_n) m_phase = PH_OPFETCH;
        default: ;
      endcase
    end
    m_pend  = nedge || (pend_old && !clr);
    m_nprev = bus.nmi_n;
  endtask

  task automatic check_all();
    logic [7:0] e_op;
    bit e_irq;
    e_op  = (m_phase == PH_OPFETCH) ? bus.mem_rdata : m_op;
    e_irq = m_pend || (!bus.irq_n && !bus.p_i) || (m_phase == PH_WAIT && !bus.irq_n);
    chk("phase",    32'(bus.phase),    32'(m_phase));
    chk("step",     32'(bus.step),     32'(m_step));
    chk("opcode",   32'(bus.opcode),   32'(e_op));
    chk("irq_req",  32'(bus.irq_req),  32'(e_irq));
    chk("int_kind", 32'(bus.int_kind), 32'(m_kind));
    chk("seq_err",  32'(bus.seq_err),  32'(m_err));
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic tick();
    if (!reset_n) model_reset();
    #1 check_all();
    @(posedge clk);
    if (reset_n) model_step();
    else model_reset();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.cpu_en = 1'b1; bus.addr_none = 1'b0; bus.addr_last = 1'b0;
    bus.exec_last = 1'b0; bus.int_last = 1'b0; bus.wai_op = 1'b0; bus.stp_op = 1'b0;
    bus.nmi_n = 1'b1; bus.irq_n = 1'b1; bus.p_i = 1'b1;
  endtask

  task automatic finish_int(input int last_at);
    for (int i = 0; i < 20 && m_phase == PH_INT; i++) begin
      bus.int_last = (m_step == last_at);
      tick();
    end
    bus.int_last = 1'b0;
    chk("int_done", 32'(bus.phase), 32'(PH_OPFETCH));
  endtask

  initial begin
    idle();
    bus.mem_rdata = 8'h00;
    model_reset();
    @(negedge clk);
    tick(); tick();
    chk("rst_phase", 32'(bus.phase), 32'(PH_RESET));
    chk("rst_step",  32'(bus.step), 32'd0);
    chk("rst_op",    32'(bus.opcode), 32'h00);

    // reset release -> INT(RESET), int_last at step 6
    reset_n = 1'b1;
    tick();
    chk("r39_int",  32'(bus.phase), 32'(PH_INT));
    chk("r39_kind", 32'(bus.int_kind), 32'(INT_RESET));
    chk("r39_step", 32'(bus.step), 32'd0);
    finish_int(6);

    // addressed instruction
    bus.mem_rdata = 8'hA9; bus.addr_none = 1'b0;
    tick();
    chk("r40_addr", 32'(bus.phase), 32'(PH_ADDR));
    bus.mem_rdata = 8'h11; bus.addr_last = 1'b1;
    tick();
    bus.addr_last = 1'b0;
    chk("r40_exec0", 32'(bus.phase), 32'(PH_EXEC));
    chk("r40_op", 32'(bus.opcode), 32'hA9);
    tick();
    chk("r40_exec1", 32'(bus.step), 32'd1);
    bus.exec_last = 1'b1;
    tick();
    bus.exec_last = 1'b0;
    chk("r40_fetch", 32'(bus.phase), 32'(PH_OPFETCH));

    // NMI pulse while disabled in EXEC
    bus.mem_rdata = 8'h3C; bus.addr_none = 1'b1;
    tick();
    bus.cpu_en = 1'b0; bus.nmi_n = 1'b0;
    tick();
    bus.nmi_n = 1'b1;
    tick();
    chk("r41_hold", 32'(bus.phase), 32'(PH_EXEC));
    bus.cpu_en = 1'b1; bus.exec_last = 1'b1;
    tick();
    bus.exec_last = 1'b0; bus.mem_rdata = 8'hFF;
    #1 chk("r41_req", 32'(bus.irq_req), 32'd1);
    tick();
    chk("r41_kind", 32'(bus.int_kind), 32'(INT_NMI));
    chk("r41_op",   32'(bus.opcode), 32'h3C);
    finish_int(2);

    // masked then unmasked IRQ
    bus.irq_n = 1'b0; bus.p_i = 1'b1; bus.mem_rdata = 8'hEA;
    #1 chk("r42_mask", 32'(bus.irq_req), 32'd0);
    tick();
    chk("r42_exec", 32'(bus.phase), 32'(PH_EXEC));
    bus.exec_last = 1'b1;
    tick();
    bus.exec_last = 1'b0; bus.p_i = 1'b0;
    #1 chk("r42_req", 32'(bus.irq_req), 32'd1);
    tick();
    chk("r42_kind", 32'(bus.int_kind), 32'(INT_IRQ));
    bus.irq_n = 1'b1; bus.p_i = 1'b1;
    finish_int(1);

    // WAI woken by masked IRQ
    bus.mem_rdata = 8'hCB;
    tick();
    bus.wai_op = 1'b1; bus.exec_last = 1'b1;
    tick();
    bus.wai_op = 1'b0; bus.exec_last = 1'b0;
    tick(); tick();
    chk("r43_wait", 32'(bus.phase), 32'(PH_WAIT));
    bus.irq_n = 1'b0;
    #1 chk("r43_req", 32'(bus.irq_req), 32'd1);
    tick();
    chk("r43_fetch", 32'(bus.phase), 32'(PH_OPFETCH));
    bus.irq_n = 1'b1; bus.mem_rdata = 8'hEA;
    tick();
    chk("r43_noint", 32'(bus.phase), 32'(PH_EXEC));
    bus.exec_last = 1'b1;
    tick();
    bus.exec_last = 1'b0;

    // step saturation and sticky error
    bus.addr_none = 1'b0;
    tick();
    repeat (SMAX + 2) tick();
    chk("sat_step", 32'(bus.step), 32'(SMAX));
    chk("sat_err",  32'(bus.seq_err), 32'd1);
    bus.addr_last = 1'b1;
    tick();
    bus.addr_last = 1'b0; bus.exec_last = 1'b1;
    tick();
    bus.exec_last = 1'b0;
    chk("err_sticky", 32'(bus.seq_err), 32'd1);

    // STP held despite NMI edges, then async reset
    bus.addr_none = 1'b1;
    tick();
    bus.stp_op = 1'b1; bus.exec_last = 1'b1;
    tick();
    bus.stp_op = 1'b0; bus.exec_last = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus.nmi_n = 1'($urandom_range(0, 1));
      bus.irq_n = 1'($urandom_range(0, 1));
      bus.mem_rdata = 8'($urandom);
      tick();
    end
    chk("r44_stop", 32'(bus.phase), 32'(PH_STOP));
    idle();
    #2 reset_n = 1'b0;
    #1 chk("r44_async", 32'(bus.phase), 32'(PH_RESET));
    chk("r44_err", 32'(bus.seq_err), 32'd0);
    model_reset();
    @(negedge clk);
    tick();
    reset_n = 1'b1;

    // randomized cycles with occasional mid-instruction resets
    for (int i = 0; i < 800; i++) begin
      bus.cpu_en    = ($urandom_range(0, 9) < 8);
      bus.mem_rdata = 8'($urandom);
      bus.addr_none = 1'($urandom_range(0, 1));
      bus.addr_last = ($urandom_range(0, 3) == 0);
      bus.exec_last = ($urandom_range(0, 2) == 0);
      bus.int_last  = ($urandom_range(0, 3) == 0);
      bus.wai_op    = ($urandom_range(0, 4) == 0);
      bus.stp_op    = ($urandom_range(0, 19) == 0);
      bus.nmi_n     = ($urandom_range(0, 9) != 0);
      bus.irq_n     = ($urandom_range(0, 6) != 0);
      bus.p_i       = 1'($urandom_range(0, 1));
      reset_n       = (i % 97 != 96);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
